// File: rtl/grasspopper_pkg.sv
// Shared constants and helpers for the grasspopper encoder front-end.
// Optional statistics counters: define GRASSPOPPER_ARB_STATS_EN.
package grasspopper_pkg;

    localparam int BLOCK_W     = 128;
    localparam int ENC_LATENCY = 162;
    localparam int MAX_REQ     = 16;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/grasspopper_fifo.sv
// Synchronous first-word-fall-through FIFO, async active-high reset.
// DEPTH must be a power of two, at least 2.
module grasspopper_fifo
    import grasspopper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is not reset, so the head is masked while empty.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/grasspopper_arbiter.sv
// Round-robin, credit-limited sharing of one grasspopper encoder pipeline.
// Define GRASSPOPPER_ARB_STATS_EN to add issue/done statistics counters.
module grasspopper_arbiter
    import grasspopper_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       enc_request_o,
    output logic [BLOCK_W-1:0]         enc_data_o,
    input  logic                       enc_valid_i,
    input  logic [BLOCK_W-1:0]         enc_data_i,
    output logic                       res_valid_o,
    output logic [BLOCK_W-1:0]         res_data_o,
    output logic [ID_W-1:0]            res_id_o,
    input  logic                       res_ready_i,
    output logic                       idle_o,
    output logic                       err_o
`ifdef GRASSPOPPER_ARB_STATS_EN
    ,
    output logic [31:0]                stat_issued_o,
    output logic [31:0]                stat_done_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = BLOCK_W + ID_W;
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [ID_W:0] NREQ     = (ID_W + 1)'(NUM_REQ);

    logic [CW-1:0]      credits;
    logic [ID_W-1:0]    ptr;
    logic               can_issue;
    logic               found;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] grant;
    logic               issue;
    logic [BLOCK_W-1:0] sel_data;
    logic               res_hs;

    logic               tag_empty;
    logic               tag_full;
    logic [ID_W-1:0]    tag;
    logic               res_empty;
    logic               res_full;
    logic               res_push;
    logic [RW-1:0]      res_word;

    // Credits cover in-flight plus stored results, so returns never overflow.
    assign can_issue = (credits < CRED_MAX);

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        sum    = '0;
        idx    = '0;
        grant  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (rst || !can_issue) begin
            found = 1'b0;
        end
        if (found) begin
            grant[gnt_id] = 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign issue       = found;
    assign sel_data    = req_data_i[int'(gnt_id)*BLOCK_W +: BLOCK_W];
    assign res_hs      = res_valid_o & res_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            enc_request_o <= 1'b0;
            enc_data_o    <= '0;
        end else begin
            enc_request_o <= issue;
            if (issue) begin
                enc_data_o <= sel_data;
                ptr        <= ID_W'(wrap_inc(int'(gnt_id), NUM_REQ));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else begin
            unique case ({issue, res_hs})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    grasspopper_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (gnt_id),
        .pop       (enc_valid_i),
        .pop_data  (tag),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // A return without a matching tag or room is dropped and flagged.
    assign res_push = enc_valid_i & ~tag_empty & ~res_full;

    grasspopper_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_push),
        .push_data ({enc_data_i, tag}),
        .pop       (res_ready_i),
        .pop_data  (res_word),
        .empty     (res_empty),
        .full      (res_full)
    );

    assign res_valid_o = ~res_empty;
    assign res_data_o  = res_word[RW-1:ID_W];
    assign res_id_o    = res_word[ID_W-1:0];
    assign idle_o      = (credits == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if ((enc_valid_i && (tag_empty || res_full)) ||
                     (issue && tag_full)) begin
            err_o <= 1'b1;
        end
    end

`ifdef GRASSPOPPER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_o <= '0;
            stat_done_o   <= '0;
        end else begin
            if (issue) begin
                stat_issued_o <= stat_issued_o + 32'd1;
            end
            if (res_hs) begin
                stat_done_o <= stat_done_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grasspopper_arbiter.sv
// Randomised bench for grasspopper_arbiter against a queue-based model,
// with a 162-cycle inverting delay line standing in for the encoder.
module tb_grasspopper_arbiter;

    localparam int N   = 4;
    localparam int LAT = 162;
    localparam int DEP = 16;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid_i;
    logic [N*128-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           enc_request_o;
    logic [127:0]   enc_data_o;
    logic           enc_valid_i;
    logic [127:0]   enc_data_i;
    logic           res_valid_o;
    logic [127:0]   res_data_o;
    logic [1:0]     res_id_o;
    logic           res_ready_i;
    logic           idle_o;
    logic           err_o;
    logic           spur;

    grasspopper_arbiter #(.NUM_REQ(N), .ID_W(2), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .enc_request_o(enc_request_o), .enc_data_o(enc_data_o),
        .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_id_o(res_id_o), .res_ready_i(res_ready_i),
        .idle_o(idle_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder stand-in: pure delay of ~data, cleared by the shared reset.
    logic         pv [LAT];
    logic [127:0] pd [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= enc_request_o;
            pd[0] <= ~enc_data_o;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign enc_valid_i = pv[LAT-1] | spur;
    assign enc_data_i  = pd[LAT-1];

    typedef struct {
        logic [1:0]   id;
        logic [127:0] d;
        longint       rdy;
    } ent_t;

    int           vec;
    int           miss;
    longint       cyc;
    int           m_ptr;
    int           m_cred;
    bit           m_err;
    bit           m_req;
    logic [127:0] m_encd;
    ent_t         q_fly[$];
    ent_t         q_res[$];
    logic [127:0] blk [N];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int exp_grant(logic [N-1:0] v);
        if (rst || m_cred >= DEP) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cred = 0; m_err = 0; m_req = 0;
        q_fly.delete();
        q_res.delete();
    endtask

    task automatic model_step(int g, bit hs);
        if (g >= 0) begin
            q_fly.push_back('{2'(g), ~blk[g], cyc + LAT + 2});
            m_ptr  = (g + 1) % N;
            m_cred++;
            m_req  = 1;
            m_encd = blk[g];
        end else begin
            m_req = 0;
        end
        if (hs) begin
            void'(q_res.pop_front());
            m_cred--;
        end
        cyc++;
        while (q_fly.size() > 0 && q_fly[0].rdy <= cyc)
            q_res.push_back(q_fly.pop_front());
    endtask

    task automatic drive(logic [N-1:0] v, bit r);
        req_valid_i = v;
        res_ready_i = r;
        for (int i = 0; i < N; i++) req_data_i[i*128 +: 128] = blk[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        drive('1, 1'b1);
        #2;
        vec += 8;
        if (req_ready_o !== 4'b0) begin miss++; $display("FAIL rst_ready got=%b exp=0", req_ready_o); end
        if (enc_request_o !== 1'b0) begin miss++; $display("FAIL rst_encreq got=%b exp=0", enc_request_o); end
        if (enc_data_o !== '0) begin miss++; $display("FAIL rst_encdata got=%h exp=0", enc_data_o); end
        if (res_valid_o !== 1'b0) begin miss++; $display("FAIL rst_resvalid got=%b exp=0", res_valid_o); end
        if (res_data_o !== '0) begin miss++; $display("FAIL rst_resdata got=%h exp=0", res_data_o); end
        if (res_id_o !== 2'd0) begin miss++; $display("FAIL rst_resid got=%0d exp=0", res_id_o); end
        if (idle_o !== 1'b1) begin miss++; $display("FAIL rst_idle got=%b exp=1", idle_o); end
        if (err_o !== 1'b0) begin miss++; $display("FAIL rst_err got=%b exp=0", err_o); end
        drive('0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single(int id, logic [127:0] data);
        int g; bit hs; logic [N-1:0] er;
        for (int i = 0; i < 175; i++) begin
            if (i == 0) blk[id] = data;
            drive((i == 0) ? N'(1 << id) : '0, 1'b1);
            @(negedge clk);
            g  = exp_grant(req_valid_i);
            hs = (q_res.size() > 0) && res_ready_i;
            er = (g >= 0) ? N'(1 << g) : '0;
            vec += 7;
            if (req_ready_o !== er) begin miss++; $display("FAIL single_grant c%0d got=%b exp=%b", i, req_ready_o, er); end
            if (enc_request_o !== m_req) begin miss++; $display("FAIL single_encreq c%0d got=%b exp=%b", i, enc_request_o, m_req); end
            if (m_req && enc_data_o !== m_encd) begin miss++; $display("FAIL single_encdata c%0d got=%h exp=%h", i, enc_data_o, m_encd); end
            if (res_valid_o !== (q_res.size() > 0)) begin miss++; $display("FAIL single_resvalid c%0d got=%b exp=%0d", i, res_valid_o, q_res.size()); end
            if (q_res.size() > 0 && {res_id_o, res_data_o} !== {q_res[0].id, q_res[0].d}) begin miss++; $display("FAIL single_res c%0d got=%0d/%h exp=%0d/%h", i, res_id_o, res_data_o, q_res[0].id, q_res[0].d); end
            if (idle_o !== (m_cred == 0)) begin miss++; $display("FAIL single_idle c%0d got=%b exp=%0d", i, idle_o, m_cred == 0); end
            if (err_o !== m_err) begin miss++; $display("FAIL single_err c%0d got=%b exp=%b", i, err_o, m_err); end
            model_step(g, hs);
            @(posedge clk);
            #1;
        end
        vec += 2;
        if (idle_o !== 1'b1) begin miss++; $display("FAIL single_idle_end got=%b exp=1", idle_o); end
        if (res_valid_o !== 1'b0) begin miss++; $display("FAIL single_drained got=%b exp=0", res_valid_o); end
    endtask

    task automatic test_round_robin();
        int g; bit hs; logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) blk[k] = rnd128();
            drive('1, 1'b1);
            @(negedge clk);
            g  = exp_grant(req_valid_i);
            hs = (q_res.size() > 0) && res_ready_i;
            er = (g >= 0) ? N'(1 << g) : '0;
            vec += 7;
            if (req_ready_o !== er) begin miss++; $display("FAIL rr_grant c%0d got=%b exp=%b", i, req_ready_o, er); end
            if (enc_request_o !== m_req) begin miss++; $display("FAIL rr_encreq c%0d got=%b exp=%b", i, enc_request_o, m_req); end
            if (m_req && enc_data_o !== m_encd) begin miss++; $display("FAIL rr_encdata c%0d got=%h exp=%h", i, enc_data_o, m_encd); end
            if (res_valid_o !== (q_res.size() > 0)) begin miss++; $display("FAIL rr_resvalid c%0d got=%b exp=%0d", i, res_valid_o, q_res.size()); end
            if (q_res.size() > 0 && {res_id_o, res_data_o} !== {q_res[0].id, q_res[0].d}) begin miss++; $display("FAIL rr_res c%0d got=%0d/%h exp=%0d/%h", i, res_id_o, res_data_o, q_res[0].id, q_res[0].d); end
            if (idle_o !== (m_cred == 0)) begin miss++; $display("FAIL rr_idle c%0d got=%b exp=%0d", i, idle_o, m_cred == 0); end
            if (err_o !== m_err) begin miss++; $display("FAIL rr_err c%0d got=%b exp=%b", i, err_o, m_err); end
            model_step(g, hs);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int g; bit hs; logic [N-1:0] er; bit r; logic [N-1:0] v;
        int n_fill; int n_one;
        n_fill = 0; n_one = 0;
        do_reset();
        for (int i = 0; i < 225; i++) begin
            for (int k = 0; k < N; k++) blk[k] = rnd128();
            r = (i == 200) || (i == 211) || (i == 212);
            v = (i == 211) ? '0 : '1;
            drive(v, r);
            @(negedge clk);
            if (i < 200 && req_ready_o != 0) n_fill++;
            if (i >= 200 && i < 211 && req_ready_o != 0) n_one++;
            g  = exp_grant(req_valid_i);
            hs = (q_res.size() > 0) && res_ready_i;
            er = (g >= 0) ? N'(1 << g) : '0;
            vec += 7;
            if (req_ready_o !== er) begin miss++; $display("FAIL bp_grant c%0d got=%b exp=%b", i, req_ready_o, er); end
            if (enc_request_o !== m_req) begin miss++; $display("FAIL bp_encreq c%0d got=%b exp=%b", i, enc_request_o, m_req); end
            if (m_req && enc_data_o !== m_encd) begin miss++; $display("FAIL bp_encdata c%0d got=%h exp=%h", i, enc_data_o, m_encd); end
            if (res_valid_o !== (q_res.size() > 0)) begin miss++; $display("FAIL bp_resvalid c%0d got=%b exp=%0d", i, res_valid_o, q_res.size()); end
            if (q_res.size() > 0 && {res_id_o, res_data_o} !== {q_res[0].id, q_res[0].d}) begin miss++; $display("FAIL bp_res c%0d got=%0d/%h exp=%0d/%h", i, res_id_o, res_data_o, q_res[0].id, q_res[0].d); end
            if (idle_o !== (m_cred == 0)) begin miss++; $display("FAIL bp_idle c%0d got=%b exp=%0d", i, idle_o, m_cred == 0); end
            if (err_o !== m_err) begin miss++; $display("FAIL bp_err c%0d got=%b exp=%b", i, err_o, m_err); end
            model_step(g, hs);
            @(posedge clk);
            #1;
        end
        vec += 2;
        if (n_fill !== DEP) begin miss++; $display("FAIL bp_fill_issues got=%0d exp=%0d", n_fill, DEP); end
        if (n_one !== 1) begin miss++; $display("FAIL bp_one_issue got=%0d exp=1", n_one); end
    endtask

    task automatic test_random();
        int g; bit hs; logic [N-1:0] er;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) blk[k] = rnd128();
            drive(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
            @(negedge clk);
            g  = exp_grant(req_valid_i);
            hs = (q_res.size() > 0) && res_ready_i;
            er = (g >= 0) ? N'(1 << g) : '0;
            vec += 7;
            if (req_ready_o !== er) begin miss++; $display("FAIL rnd_grant c%0d got=%b exp=%b", i, req_ready_o, er); end
            if (enc_request_o !== m_req) begin miss++; $display("FAIL rnd_encreq c%0d got=%b exp=%b", i, enc_request_o, m_req); end
            if (m_req && enc_data_o !== m_encd) begin miss++; $display("FAIL rnd_encdata c%0d got=%h exp=%h", i, enc_data_o, m_encd); end
            if (res_valid_o !== (q_res.size() > 0)) begin miss++; $display("FAIL rnd_resvalid c%0d got=%b exp=%0d", i, res_valid_o, q_res.size()); end
            if (q_res.size() > 0 && {res_id_o, res_data_o} !== {q_res[0].id, q_res[0].d}) begin miss++; $display("FAIL rnd_res c%0d got=%0d/%h exp=%0d/%h", i, res_id_o, res_data_o, q_res[0].id, q_res[0].d); end
            if (idle_o !== (m_cred == 0)) begin miss++; $display("FAIL rnd_idle c%0d got=%b exp=%0d", i, idle_o, m_cred == 0); end
            if (err_o !== m_err) begin miss++; $display("FAIL rnd_err c%0d got=%b exp=%b", i, err_o, m_err); end
            model_step(g, hs);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_spurious();
        do_reset();
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vec += 2;
            if (err_o !== 1'b1) begin miss++; $display("FAIL spur_err c%0d got=%b exp=1", i, err_o); end
            if (res_valid_o !== 1'b0) begin miss++; $display("FAIL spur_resvalid c%0d got=%b exp=0", i, res_valid_o); end
            @(posedge clk);
            #1;
        end
        do_reset();
        vec++;
        if (err_o !== 1'b0) begin miss++; $display("FAIL spur_clear got=%b exp=0", err_o); end
    endtask

    task automatic test_mid_reset();
        int g; int n;
        do_reset();
        n = 0;
        while (m_cred < 10 && n < 30) begin
            for (int k = 0; k < N; k++) blk[k] = rnd128();
            drive('1, 1'b1);
            @(negedge clk);
            g = exp_grant(req_valid_i);
            model_step(g, 1'b0);
            @(posedge clk);
            #1;
            n++;
        end
        vec++;
        if (m_cred != 10) begin miss++; $display("FAIL midrst_fill got=%0d exp=10", m_cred); end
        #2 rst = 1'b1;
        #1;
        vec += 8;
        if (req_ready_o !== 4'b0) begin miss++; $display("FAIL midrst_ready got=%b exp=0", req_ready_o); end
        if (enc_request_o !== 1'b0) begin miss++; $display("FAIL midrst_encreq got=%b exp=0", enc_request_o); end
        if (enc_data_o !== '0) begin miss++; $display("FAIL midrst_encdata got=%h exp=0", enc_data_o); end
        if (res_valid_o !== 1'b0) begin miss++; $display("FAIL midrst_resvalid got=%b exp=0", res_valid_o); end
        if (res_data_o !== '0) begin miss++; $display("FAIL midrst_resdata got=%h exp=0", res_data_o); end
        if (res_id_o !== 2'd0) begin miss++; $display("FAIL midrst_resid got=%0d exp=0", res_id_o); end
        if (idle_o !== 1'b1) begin miss++; $display("FAIL midrst_idle got=%b exp=1", idle_o); end
        if (err_o !== 1'b0) begin miss++; $display("FAIL midrst_err got=%b exp=0", err_o); end
        model_reset();
        drive('0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        test_single(2, 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    endtask

    initial begin
        vec = 0; miss = 0; cyc = 0;
        rst = 1'b1; spur = 1'b0;
        for (int k = 0; k < N; k++) blk[k] = '0;
        model_reset();
        drive('0, 1'b0);
        test_reset();
        test_single(0, 128'h00112233445566778899AABBCCDDEEFF);
        test_round_robin();
        test_backpressure();
        test_random();
        test_spurious();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
